// File: rtl/rcosc_rst_sequencer.sv
// Reset-release sequencer for the UART-to-SPI bridge fabric, clocked by the 160 MHz RC oscillator.
// Holds reset through power-on, waits for a stable PLL lock, then releases fabric and core resets in stages.
//
// state     | meaning
// ----------+---------------------------------------------------------
// POR_WAIT  | power-on hold, lock ignored
// LOCK_WAIT | waiting for synchronised lock
// STABLE    | lock seen, counting consecutive stable cycles
// GAP       | fabric released, counting down to core release
// RUN       | both resets released, READY high
module rcosc_rst_sequencer #(
    parameter int POR_CYCLES    = 1600,
    parameter int STABLE_CYCLES = 256,
    parameter int STAGE_GAP     = 64,
    parameter int CNT_W         = 16
) (
    input  logic       RCOSC_160MHZ_GL,
    input  logic       RESETN,
    input  logic       PLL_LOCK,
    output logic       FABRIC_RESETN,
    output logic       CORE_RESETN,
    output logic       READY,
    output logic [7:0] LOCK_LOSS_CNT,
    output logic [2:0] STATE_DBG
);

    localparam logic [2:0] ST_POR_WAIT  = 3'd0;
    localparam logic [2:0] ST_LOCK_WAIT = 3'd1;
    localparam logic [2:0] ST_STABLE    = 3'd2;
    localparam logic [2:0] ST_GAP       = 3'd3;
    localparam logic [2:0] ST_RUN       = 3'd4;

    localparam logic [CNT_W-1:0] POR_LAST    = CNT_W'(POR_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             lock_meta;
    logic             lock_s;

    assign STATE_DBG = state;

    always_ff @(posedge RCOSC_160MHZ_GL) begin
        if (!RESETN) begin
            state         <= ST_POR_WAIT;
            cnt           <= '0;
            lock_meta     <= 1'b0;
            lock_s        <= 1'b0;
            FABRIC_RESETN <= 1'b0;
            CORE_RESETN   <= 1'b0;
            READY         <= 1'b0;
            LOCK_LOSS_CNT <= 8'd0;
        end else begin
            lock_meta <= PLL_LOCK;
            lock_s    <= lock_meta;
            case (state)
                ST_POR_WAIT: begin
                    if (cnt == POR_LAST) begin
                        state <= ST_LOCK_WAIT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_LOCK_WAIT: begin
                    if (lock_s) begin
                        state <= ST_STABLE;
                        cnt   <= '0;
                    end
                end
                ST_STABLE: begin
                    // a drop before the fabric is released is not counted as a loss
                    if (!lock_s) begin
                        state <= ST_LOCK_WAIT;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        state         <= ST_GAP;
                        cnt           <= '0;
                        FABRIC_RESETN <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_GAP: begin
                    if (!lock_s) begin
                        state         <= ST_LOCK_WAIT;
                        cnt           <= '0;
                        FABRIC_RESETN <= 1'b0;
                        if (LOCK_LOSS_CNT != 8'hFF) LOCK_LOSS_CNT <= LOCK_LOSS_CNT + 8'd1;
                    end else if (cnt == GAP_LAST) begin
                        state       <= ST_RUN;
                        cnt         <= '0;
                        CORE_RESETN <= 1'b1;
                        READY       <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state         <= ST_LOCK_WAIT;
                        cnt           <= '0;
                        FABRIC_RESETN <= 1'b0;
                        CORE_RESETN   <= 1'b0;
                        READY         <= 1'b0;
                        if (LOCK_LOSS_CNT != 8'hFF) LOCK_LOSS_CNT <= LOCK_LOSS_CNT + 8'd1;
                    end
                end
                default: begin
                    // illegal encodings recover like a reset but keep the debug count
                    state         <= ST_POR_WAIT;
                    cnt           <= '0;
                    lock_meta     <= 1'b0;
                    lock_s        <= 1'b0;
                    FABRIC_RESETN <= 1'b0;
                    CORE_RESETN   <= 1'b0;
                    READY         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rcosc_rst_sequencer.sv
// Bench for rcosc_rst_sequencer: checkpoint table, hand-written corner sequences and
// randomized lock stimulus compared against a run-length reference model.
module tb_rcosc_rst_sequencer;

    localparam int P = 16;
    localparam int S = 8;
    localparam int G = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lock = 1'b0;
    logic       fab, core, ready;
    logic [7:0] loss_cnt;
    logic [2:0] st;

    rcosc_rst_sequencer #(
        .POR_CYCLES(P), .STABLE_CYCLES(S), .STAGE_GAP(G), .CNT_W(8)
    ) dut (
        .RCOSC_160MHZ_GL(clk),
        .RESETN(rst_n),
        .PLL_LOCK(lock),
        .FABRIC_RESETN(fab),
        .CORE_RESETN(core),
        .READY(ready),
        .LOCK_LOSS_CNT(loss_cnt),
        .STATE_DBG(st)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    int edge_no = 0;

    // Reference model: edges since reset, a 2-deep lock delay line, and the length of the
    // current unbroken run of synchronised lock seen after the power-on hold.
    int m_e = 0;
    int m_run = 0;
    int m_cnt = 0;
    bit m_d1 = 1'b0;
    bit m_d2 = 1'b0;

    task automatic model_edge(input bit r, input bit l);
        bit ls;
        if (!r) begin
            m_e = 0; m_run = 0; m_cnt = 0; m_d1 = 0; m_d2 = 0;
            edge_no = 0;
        end else begin
            edge_no++;
            ls = m_d2;
            m_d2 = m_d1;
            m_d1 = l;
            if (m_e < P) begin
                m_e++;
            end else if (ls) begin
                if (m_run < S + G + 1) m_run++;
            end else begin
                if (m_run >= S + 1 && m_cnt < 255) m_cnt++;
                m_run = 0;
            end
        end
    endtask

    function automatic int exp_state();
        if (m_e < P) return 0;
        if (m_run == 0) return 1;
        if (m_run <= S) return 2;
        if (m_run <= S + G) return 3;
        return 4;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s @edge %0d: got %0d expected %0d", name, edge_no, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(rst_n, lock);
        #1;
        chk("fabric_model", int'(fab), int'(m_e >= P && m_run >= S + 1));
        chk("core_model", int'(core), int'(m_run >= S + G + 1));
        chk("ready_model", int'(ready), int'(m_run >= S + G + 1));
        chk("state_model", int'(st), exp_state());
        chk("losscnt_model", int'(loss_cnt), m_cnt);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) tick();
        rst_n = 1'b1;
    endtask

    task automatic run_to(input int e);
        int guard = 0;
        while (edge_no < e && guard < 1000) begin
            tick();
            guard++;
        end
    endtask

    task automatic wait_state(input int target, input int budget);
        int n = 0;
        while (int'(st) != target && n < budget) begin
            tick();
            n++;
        end
        chk("wait_state", int'(st), target);
    endtask

    typedef struct {
        int       edge_n;
        bit       fab;
        bit       core;
        bit [2:0] st;
    } vec_t;

    vec_t tbl[9];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1, 0, 0, 0};
        tbl[1] = '{15, 0, 0, 0};
        tbl[2] = '{16, 0, 0, 1};
        tbl[3] = '{17, 0, 0, 2};
        tbl[4] = '{24, 0, 0, 2};
        tbl[5] = '{25, 1, 0, 3};
        tbl[6] = '{28, 1, 0, 3};
        tbl[7] = '{29, 1, 1, 4};
        tbl[8] = '{35, 1, 1, 4};

        // lock held high from reset
        lock = 1'b1;
        do_reset(2);
        chk("reset_fabric", int'(fab), 0);
        chk("reset_state", int'(st), 0);
        for (int i = 0; i < 9; i++) begin
            run_to(tbl[i].edge_n);
            chk("tbl_fabric", int'(fab), int'(tbl[i].fab));
            chk("tbl_core", int'(core), int'(tbl[i].core));
            chk("tbl_ready", int'(ready), int'(tbl[i].core));
            chk("tbl_state", int'(st), int'(tbl[i].st));
        end
        chk("tbl_losscnt", int'(loss_cnt), 0);

        // late lock: first sampled high at edge 40
        lock = 1'b0;
        do_reset(2);
        run_to(39);
        lock = 1'b1;
        run_to(41);
        chk("late_state_wait", int'(st), 1);
        run_to(49);
        chk("late_fabric_low", int'(fab), 0);
        run_to(50);
        chk("late_fabric_high", int'(fab), 1);
        run_to(53);
        chk("late_core_low", int'(core), 0);
        run_to(54);
        chk("late_core_high", int'(core), 1);
        chk("late_ready_high", int'(ready), 1);

        // 3-cycle lock drop in the middle of STABLE
        lock = 1'b1;
        do_reset(1);
        run_to(20);
        lock = 1'b0;
        run_to(23);
        lock = 1'b1;
        run_to(33);
        chk("drop_fabric_held", int'(fab), 0);
        run_to(34);
        chk("drop_fabric_rel", int'(fab), 1);
        chk("drop_losscnt", int'(loss_cnt), 0);

        // loss from RUN, then relock without a new POR hold
        run_to(45);
        lock = 1'b0;
        run_to(47);
        chk("loss_fabric_still", int'(fab), 1);
        run_to(48);
        chk("loss_fabric", int'(fab), 0);
        chk("loss_core", int'(core), 0);
        chk("loss_ready", int'(ready), 0);
        chk("loss_cnt1", int'(loss_cnt), 1);
        chk("loss_state", int'(st), 1);
        lock = 1'b1;
        run_to(62);
        chk("relock_gap", int'(st), 3);
        run_to(63);
        chk("relock_run", int'(st), 4);

        // repeated losses saturate the debug count
        for (int k = 0; k < 300; k++) begin
            lock = 1'b0;
            repeat (3) tick();
            lock = 1'b1;
            wait_state(4, 40);
        end
        chk("sat_cnt", int'(loss_cnt), 255);

        // one-cycle reset while in GAP restarts the full hold
        wait_state(4, 5);
        lock = 1'b0;
        repeat (3) tick();
        lock = 1'b1;
        wait_state(3, 40);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("gaprst_state", int'(st), 0);
        chk("gaprst_fabric", int'(fab), 0);
        chk("gaprst_core", int'(core), 0);
        chk("gaprst_cnt", int'(loss_cnt), 0);
        run_to(15);
        chk("gaprst_por_hold", int'(st), 0);
        run_to(16);
        chk("gaprst_por_done", int'(st), 1);

        // randomized lock runs with occasional resets
        for (int seg = 0; seg < 300; seg++) begin
            int len;
            lock = ($urandom_range(0, 3) != 0);
            len = lock ? $urandom_range(1, 24) : $urandom_range(1, 5);
            if ($urandom_range(0, 60) == 0) do_reset(1);
            repeat (len) tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
